nibble_gather: RTL and testbench

//  - Receive-side counterpart to the nibble fan-out used by submodule instance

---
 rtl/nibble_gather_pkg.sv | 12 +
 rtl/nibble_lane.sv | 26 ++
 rtl/nibble_gather.sv | 134 +++++++++++++
 tb/tb_nibble_gather.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_gather_pkg.sv
// Shared defaults and sizing helpers for the nibble_gather block.
package nibble_gather_pkg;

  localparam int NLANES_DEF = 8;
  localparam int LANE_W_DEF = 4;

  // Width needed to hold a lane count in the range 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nibble_lane.sv
// One capture register of the gather array: LANE_W bits, synchronous clear,
// loaded when its write enable is high.
module nibble_lane #(
  parameter int LANE_W = 4
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] d_i,
  output logic [LANE_W-1:0] q_o
);

  logic [LANE_W-1:0] q_q;

  // Capture the nibble when this lane is selected; clear takes priority.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/nibble_gather.sv
// nibble_gather: collects a serial stream of LANE_W-bit nibbles into an
// NLANES*LANE_W word presented on a valid/ready output. The first nibble of a
// word lands in lane 0 (LSBs). Lanes refill while the previous word is held.
// Optional feature: define NIBBLE_GATHER_FLUSH_EN to add the in_flush port,
// which emits a partially filled word with the unfilled lanes read as zero.
module nibble_gather
  import nibble_gather_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LANE_W-1:0]            in_data,
  output logic                         in_ready,
`ifdef NIBBLE_GATHER_FLUSH_EN
  input  logic                         in_flush,
`endif
  output logic                         out_valid,
  output logic [NLANES*LANE_W-1:0]     out_data,
  output logic [count_w(NLANES)-1:0]   out_count,
  input  logic                         out_ready
);

  localparam int PTR_W = $clog2(NLANES);
  localparam int CNT_W = count_w(NLANES);
  localparam int WORD_W = NLANES * LANE_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NLANES - 1);

  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic              out_valid_q;
  logic [WORD_W-1:0] out_data_q;
  logic [CNT_W-1:0]  out_count_q;

  logic [NLANES-1:0] lane_we;
  logic [WORD_W-1:0] lane_q;
  logic [WORD_W-1:0] word_d;
  logic [CNT_W-1:0]  count_d;

  logic hold_block;
  logic flush_req;
  logic accept;
  logic complete;
  logic flush_go;
  logic emit;

  // A held word that is not being taken this cycle blocks a new emission.
  assign hold_block = out_valid_q & ~out_ready;

`ifdef NIBBLE_GATHER_FLUSH_EN
  assign flush_req = in_flush;
`else
  assign flush_req = 1'b0;
`endif

  // Independent of in_valid so that no combinational loop can form upstream.
  assign in_ready = ~rst & ~(((ptr_q == LAST) | flush_req) & hold_block);
  assign accept   = in_valid & in_ready;
  assign complete = accept & (ptr_q == LAST);
  // A flush needs something to emit: a filled lane or a nibble arriving now.
  assign flush_go = flush_req & ~rst & ~hold_block & ((ptr_q != '0) | accept);
  assign emit     = complete | flush_go;

  // Decode the write pointer into one lane write enable.
  always_comb begin
    lane_we = '0;
    if (accept) begin
      lane_we[ptr_q] = 1'b1;
    end
  end

  nibble_lane #(.LANE_W(LANE_W)) lane [NLANES-1:0] (
    .clk   (clk),
    .clr_i (rst),
    .we_i  (lane_we),
    .d_i   (in_data),
    .q_o   (lane_q)
  );

  // Assemble the outgoing word: filled lanes, the nibble arriving this cycle
  // in the current lane, zero above it (stale lane contents never escape).
  always_comb begin
    word_d = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (PTR_W'(k) < ptr_q) begin
        word_d[k*LANE_W +: LANE_W] = lane_q[k*LANE_W +: LANE_W];
      end else if ((PTR_W'(k) == ptr_q) && accept) begin
        word_d[k*LANE_W +: LANE_W] = in_data;
      end
    end
    count_d = accept ? (CNT_W'(ptr_q) + CNT_W'(1)) : CNT_W'(ptr_q);
  end

  // Next write pointer: restart at lane 0 whenever a word leaves.
  always_comb begin
    ptr_d = ptr_q;
    if (emit) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Write pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Output word register: load on emission, drop valid once taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word_d;
      out_count_q <= count_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_nibble_gather.sv
// Self-checking bench for nibble_gather (NLANES=8, LANE_W=4). Expected words
// are queued as nibbles are driven; words taken by the consumer are captured
// at the clock edge and compared against the queue in each scenario.
module tb_nibble_gather;

  localparam int NL = 8;
  localparam int LW = 4;
  localparam int DW = NL * LW;
  localparam int CW = $clog2(NL + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [LW-1:0] in_data;
  logic          in_ready;
`ifdef NIBBLE_GATHER_FLUSH_EN
  logic          in_flush;
`endif
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  int send_timeouts = 0;

  logic [DW+CW-1:0] exp_q[$];
  logic [DW+CW-1:0] got_q[$];
  logic [DW+CW-1:0] g;
  logic [DW+CW-1:0] e;

  nibble_gather #(.NLANES(NL), .LANE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef NIBBLE_GATHER_FLUSH_EN
    .in_flush  (in_flush),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every word the consumer takes.
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back({out_data, out_count});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one nibble and hold it until accepted (bounded).
  task automatic send(input logic [LW-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) send_timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'hF;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready cyc%0d got %b want 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    checks++;
    if (out_count !== '0) begin
      errors++;
      $display("FAIL reset_out_count got %0d want 0", out_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    out_ready = 1'b1;
    exp_q.push_back({32'h76543210, 4'd8});
    t0 = $time;
    for (int i = 0; i < NL; i++) send(LW'(i));
    t1 = $time;
    in_valid = 1'b0;
    checks++;
    if ((t1 - t0) > (NL * 10 + 2)) begin
      errors++;
      $display("FAIL b2b_throughput got %0d ns want <= %0d", t1 - t0, NL * 10 + 2);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h76543210 || out_count !== 4'd8) begin
      errors++;
      $display("FAIL b2b_word got v=%b %h/%0d want v=1 76543210/8", out_valid, out_data, out_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_drop got %b want 0", out_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_sb missing word got none want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL b2b_sb got %h want %h", g, e);
        end
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    exp_q.push_back({32'hAAAAAAAA, 4'd8});
    for (int i = 0; i < NL; i++) send(4'hA);
    exp_q.push_back({32'h55555555, 4'd8});
    for (int i = 0; i < NL - 1; i++) send(4'h5);
    in_valid = 1'b1;
    in_data = 4'h5;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_data !== 32'hAAAAAAAA || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got rdy=%b v=%b %h want rdy=0 v=1 aaaaaaaa",
                 i, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55555555) begin
      errors++;
      $display("FAIL stall_second_word got v=%b %h want v=1 55555555", out_valid, out_data);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL stall_sb missing word got none want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL stall_sb got %h want %h", g, e);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [LW-1:0] w2 [NL];
    w2 = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    out_ready = 1'b0;
    exp_q.push_back({32'h87654321, 4'd8});
    for (int i = 0; i < NL; i++) send(LW'(i + 1));
    exp_q.push_back({32'h0FEDCBA9, 4'd8});
    for (int i = 0; i < NL - 1; i++) send(w2[i]);
    out_ready = 1'b1;
    send(w2[NL-1]);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0FEDCBA9) begin
      errors++;
      $display("FAIL collide_word got v=%b %h want v=1 0fedcba9", out_valid, out_data);
    end
    tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL collide_count got %0d words want 2", got_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL collide_sb missing word got none want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL collide_sb got %h want %h", g, e);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    send(4'h1);
    send(4'h2);
    send(4'h3);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back({32'h76543210, 4'd8});
    for (int i = 0; i < NL; i++) send(LW'(i));
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'h76543210) begin
      errors++;
      $display("FAIL midrst_word got %h want 76543210", out_data);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL midrst_sb missing word got none want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL midrst_sb got %h want %h", g, e);
        end
      end
    end
  endtask

`ifdef NIBBLE_GATHER_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1;
    send(4'hC);
    send(4'hD);
    in_valid = 1'b0;
    in_flush = 1'b1;
    exp_q.push_back({32'h000000DC, 4'd2});
    tick();
    in_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h000000DC || out_count !== 4'd2) begin
      errors++;
      $display("FAIL flush_word got v=%b %h/%0d want v=1 000000dc/2", out_valid, out_data, out_count);
    end
    exp_q.push_back({32'h76543210, 4'd8});
    for (int i = 0; i < NL; i++) send(LW'(i));
    in_valid = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL flush_sb missing word got none want %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL flush_sb got %h want %h", g, e);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef NIBBLE_GATHER_FLUSH_EN
    in_flush = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_stall();
    test_collision();
    test_mid_reset();
`ifdef NIBBLE_GATHER_FLUSH_EN
    test_flush();
`endif
    checks++;
    if (send_timeouts != 0) begin
      errors++;
      $display("FAIL send_timeout got %0d timeouts want 0", send_timeouts);
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL extra_words got %0d unexpected words want 0", got_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
